// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM persistence controller.
// The format header is stored in RAM address order 0..3.
package bk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER_REQ,
        XFER_WAIT,
        FORMAT
    } bk_state_t;

    localparam int FMT_WORDS = 4;

    localparam logic [15:0] FMT_HEADER [FMT_WORDS] = '{
        16'h5548, 16'h4D42, 16'h8800, 16'h8010
    };

    function automatic logic [15:0] fmt_word(input logic [1:0] idx);
        return FMT_HEADER[idx];
    endfunction

endpackage

// File: rtl/bk_autosave_timer.sv
// Idle-tick counter that requests a save once RAM has been dirty and untouched
// for TICKS frame ticks. TICKS = 0 disables the expiry pulse entirely.
module bk_autosave_timer #(
    parameter int TICKS = 120
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic run,
    input  logic bram_wr,
    input  logic tick,
    output logic expire
);

    localparam int           CW   = (TICKS < 2) ? 1 : $clog2(TICKS + 1);
    localparam bit           ENA  = (TICKS != 0);
    localparam logic [CW-1:0] LAST = ENA ? CW'(TICKS - 1) : '0;

    logic [CW-1:0] count_reg;
    logic          expire_reg;

    always_ff @(posedge clk_sys) begin
        if (reset || !run || bram_wr) begin
            count_reg  <= '0;
            expire_reg <= 1'b0;
        end else if (tick) begin
            if (count_reg == LAST) begin
                count_reg  <= '0;
                expire_reg <= ENA;
            end else begin
                count_reg  <= count_reg + 1'b1;
                expire_reg <= 1'b0;
            end
        end else begin
            expire_reg <= 1'b0;
        end
    end

    assign expire = expire_reg;

endmodule

// File: rtl/bkram_sd_ctrl.sv
// Moves a save-RAM image between dual-port RAM port B and the HPS SD sector
// interface: slot-based load/save, header format, dirty tracking, auto-save.
module bkram_sd_ctrl
    import bk_pkg::*;
#(
    parameter int SECTOR_BITS    = 4,
    parameter int SLOT_BITS      = 2,
    parameter int AUTOSAVE_TICKS = 120
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    bk_ena,
    input  logic                    load_req,
    input  logic                    save_req,
    input  logic                    format_req,
    input  logic [SLOT_BITS-1:0]    slot,
    input  logic                    autosave_en,
    input  logic                    tick,
    input  logic                    bram_wr,
    output logic [31:0]             sd_lba,
    output logic                    sd_rd,
    output logic                    sd_wr,
    input  logic                    sd_ack,
    input  logic [7:0]              sd_buff_addr,
    input  logic [15:0]             sd_buff_dout,
    input  logic                    sd_buff_wr,
    output logic [SECTOR_BITS+7:0]  ram_addr,
    output logic [15:0]             ram_din,
    output logic                    ram_we,
    output logic                    busy,
    output logic                    loading,
    output logic                    dirty
);

    localparam int LBA_W = SLOT_BITS + SECTOR_BITS;
    localparam int AW    = SECTOR_BITS + 8;

    logic [2:0] req_vec;
    logic [2:0] req_evt;
    logic       ack_prev_reg;
    logic       ack_rise;
    logic       ack_fall;
    logic       auto_evt;
    logic       start_load;
    logic       start_save;
    logic       start_fmt;

    bk_state_t        state_reg;
    logic [LBA_W-1:0] sd_lba_reg;
    logic             sd_rd_reg;
    logic             sd_wr_reg;
    logic             busy_reg;
    logic             loading_reg;
    logic             is_load_reg;
    logic             dirty_reg;
    logic [1:0]       fmt_idx_reg;

    assign req_vec = {format_req, save_req, load_req};

    // The previous-value registers keep tracking during reset so that a
    // request level held through reset is not mistaken for a new edge.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            logic prev_reg;
            logic evt_reg;
            always_ff @(posedge clk_sys) begin
                prev_reg <= req_vec[gi];
                if (reset) begin
                    evt_reg <= 1'b0;
                end else begin
                    evt_reg <= req_vec[gi] & ~prev_reg;
                end
            end
            assign req_evt[gi] = evt_reg;
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        ack_prev_reg <= sd_ack;
    end

    assign ack_rise = sd_ack & ~ack_prev_reg;
    assign ack_fall = ~sd_ack & ack_prev_reg;

    bk_autosave_timer #(
        .TICKS(AUTOSAVE_TICKS)
    ) u_timer (
        .clk_sys (clk_sys),
        .reset   (reset),
        .run     (autosave_en & dirty_reg & (state_reg == IDLE)),
        .bram_wr (bram_wr),
        .tick    (tick),
        .expire  (auto_evt)
    );

    always_comb begin
        start_load = 1'b0;
        start_save = 1'b0;
        start_fmt  = 1'b0;
        if (state_reg == IDLE && bk_ena) begin
            start_load = req_evt[0];
            start_save = !req_evt[0] && (req_evt[1] || (!req_evt[2] && auto_evt));
            start_fmt  = !req_evt[0] && !req_evt[1] && req_evt[2];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg   <= IDLE;
            sd_lba_reg  <= '0;
            sd_rd_reg   <= 1'b0;
            sd_wr_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            loading_reg <= 1'b0;
            is_load_reg <= 1'b0;
            dirty_reg   <= 1'b0;
            fmt_idx_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_load || start_save) begin
                        sd_lba_reg  <= {slot, {SECTOR_BITS{1'b0}}};
                        is_load_reg <= start_load;
                        loading_reg <= start_load;
                        sd_rd_reg   <= start_load;
                        sd_wr_reg   <= ~start_load;
                        busy_reg    <= 1'b1;
                        state_reg   <= XFER_REQ;
                        if (start_save) begin
                            dirty_reg <= 1'b0;
                        end
                    end else if (start_fmt) begin
                        fmt_idx_reg <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= FORMAT;
                    end
                end
                XFER_REQ: begin
                    if (ack_rise) begin
                        sd_rd_reg <= 1'b0;
                        sd_wr_reg <= 1'b0;
                        state_reg <= XFER_WAIT;
                    end
                end
                XFER_WAIT: begin
                    if (ack_fall) begin
                        if (&sd_lba_reg[SECTOR_BITS-1:0]) begin
                            busy_reg    <= 1'b0;
                            loading_reg <= 1'b0;
                            state_reg   <= IDLE;
                            if (is_load_reg) begin
                                dirty_reg <= 1'b0;
                            end
                        end else begin
                            sd_lba_reg <= sd_lba_reg + 1'b1;
                            sd_rd_reg  <= is_load_reg;
                            sd_wr_reg  <= ~is_load_reg;
                            state_reg  <= XFER_REQ;
                        end
                    end
                end
                FORMAT: begin
                    fmt_idx_reg <= fmt_idx_reg + 1'b1;
                    if (fmt_idx_reg == 2'(FMT_WORDS - 1)) begin
                        busy_reg  <= 1'b0;
                        dirty_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            // A core write always wins over any clear issued in the same cycle.
            if (bram_wr) begin
                dirty_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        if (state_reg == FORMAT) begin
            ram_addr = AW'(fmt_idx_reg);
            ram_din  = fmt_word(fmt_idx_reg);
            ram_we   = 1'b1;
        end else begin
            ram_addr = {sd_lba_reg[SECTOR_BITS-1:0], sd_buff_addr};
            ram_din  = sd_buff_dout;
            ram_we   = sd_buff_wr & sd_ack & loading_reg;
        end
    end

    assign sd_lba  = 32'(sd_lba_reg);
    assign sd_rd   = sd_rd_reg;
    assign sd_wr   = sd_wr_reg;
    assign busy    = busy_reg;
    assign loading = loading_reg;
    assign dirty   = dirty_reg;

endmodule

// File: tb/tb_bkram_sd_ctrl.sv
// Randomised bench for bkram_sd_ctrl: acts as the SD host and checks every
// handshake, RAM write and flag against a sector-level model of each operation.
module tb_bkram_sd_ctrl;

    localparam int SB = 4;
    localparam int LB = 2;
    localparam int AT = 3;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          bk_ena = 1'b1;
    logic          load_req = 1'b0;
    logic          save_req = 1'b0;
    logic          format_req = 1'b0;
    logic [LB-1:0] slot = '0;
    logic          autosave_en = 1'b0;
    logic          tick = 1'b0;
    logic          bram_wr = 1'b0;
    logic [31:0]   sd_lba;
    logic          sd_rd;
    logic          sd_wr;
    logic          sd_ack = 1'b0;
    logic [7:0]    sd_buff_addr = '0;
    logic [15:0]   sd_buff_dout = '0;
    logic          sd_buff_wr = 1'b0;
    logic [SB+7:0] ram_addr;
    logic [15:0]   ram_din;
    logic          ram_we;
    logic          busy;
    logic          loading;
    logic          dirty;

    int checks = 0;
    int errors = 0;
    bit model_dirty = 1'b0;
    logic [15:0] fmt_exp [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

    bkram_sd_ctrl #(
        .SECTOR_BITS(SB), .SLOT_BITS(LB), .AUTOSAVE_TICKS(AT)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .bk_ena(bk_ena),
        .load_req(load_req), .save_req(save_req), .format_req(format_req),
        .slot(slot), .autosave_en(autosave_en), .tick(tick), .bram_wr(bram_wr),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .busy(busy), .loading(loading), .dirty(dirty)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
    endtask

    // Raise the request lines; nothing moves after the sampling edge, the
    // operation is visible one edge later.
    task automatic start(input bit ld, input bit sv, input bit fm, input logic [LB-1:0] sl);
        slot = sl;
        load_req = ld;
        save_req = sv;
        format_req = fm;
        step();
        check("start_quiet", {29'd0, sd_rd, sd_wr, busy}, 32'd0);
        step();
        check("start_busy", busy, 1);
        load_req = 1'b0;
        save_req = 1'b0;
        format_req = 1'b0;
    endtask

    task automatic serve(input bit is_load, input logic [31:0] base, input int n_sect,
                         input int wr_sect, input int poke_sect, output int hs);
        hs = 0;
        for (int s = 0; s < n_sect; s++) begin
            int t = 0;
            while (!(sd_rd || sd_wr) && t < 100) begin
                step();
                t++;
            end
            if (!(sd_rd || sd_wr)) begin
                check("req_timeout", 0, 1);
                return;
            end
            check("req_rd", sd_rd, is_load);
            check("req_wr", sd_wr, !is_load);
            check("lba", sd_lba, base + s);
            check("busy_xfer", busy, 1);
            check("loading_xfer", loading, is_load);
            if (s == poke_sect) save_req = 1'b1;
            if (s == wr_sect) begin
                bram_wr = 1'b1;
                model_dirty = 1'b1;
            end
            step();
            bram_wr = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                check("req_held", sd_rd | sd_wr, 1);
                step();
            end
            sd_ack = 1'b1;
            hs++;
            step();
            check("req_drop", sd_rd | sd_wr, 0);
            for (int k = $urandom_range(1, 3); k > 0; k--) begin
                sd_buff_addr = 8'($urandom);
                sd_buff_dout = 16'($urandom);
                sd_buff_wr = 1'b1;
                #1;
                check("ram_we", ram_we, is_load);
                if (is_load) begin
                    check("ram_addr", ram_addr, {s[SB-1:0], sd_buff_addr});
                    check("ram_din", ram_din, sd_buff_dout);
                end
                step();
            end
            sd_buff_wr = 1'b0;
            sd_ack = 1'b0;
        end
    endtask

    task automatic finish_op(input string name, input bit is_load, input int sl, input int hs);
        step();
        if (is_load) model_dirty = 1'b0;
        check("end_busy", busy, 0);
        check("end_loading", loading, 0);
        check("end_dirty", dirty, model_dirty);
        check("handshakes", hs, 16);
        $display("op %s %s slot %0d handshakes %0d dirty %0b", name,
                 is_load ? "load" : "save", sl, hs, dirty);
    endtask

    initial begin
        int hs;
        int t;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_rd", sd_rd, 0);
        check("rst_wr", sd_wr, 0);
        check("rst_busy", busy, 0);
        check("rst_loading", loading, 0);
        check("rst_dirty", dirty, 0);
        check("rst_we", ram_we, 0);
        check("rst_lba", sd_lba, 0);

        // Directed load of slot 2 with RAM dirty beforehand.
        bram_wr = 1'b1; step(); bram_wr = 1'b0; model_dirty = 1'b1; step();
        check("pre_dirty", dirty, 1);
        start(1, 0, 0, 2);
        check("load_keep_dirty", dirty, 1);
        serve(1, 32'h20, 16, 99, 99, hs);
        finish_op("directed", 1, 2, hs);

        // Directed save of slot 1, core write during sector 5.
        bram_wr = 1'b1; step(); bram_wr = 1'b0; step();
        start(0, 1, 0, 1);
        model_dirty = 1'b0;
        check("save_clr", dirty, 0);
        serve(0, 32'h10, 16, 5, 99, hs);
        finish_op("directed", 0, 1, hs);

        // Load and save in the same cycle, then a save edge while busy.
        start(1, 1, 0, 3);
        serve(1, 32'h30, 16, 99, 3, hs);
        finish_op("simultaneous", 1, 3, hs);
        save_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("dropped_evt", {30'd0, sd_wr, busy}, 0);
            step();
        end

        // Format writes the header and marks RAM dirty.
        start(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            check("fmt_we", ram_we, 1);
            check("fmt_addr", ram_addr, i);
            check("fmt_data", ram_din, fmt_exp[i]);
            step();
        end
        model_dirty = 1'b1;
        check("fmt_done_we", ram_we, 0);
        check("fmt_busy", busy, 0);
        check("fmt_dirty", dirty, 1);
        $display("op format header words 4 dirty %0b", dirty);

        // Randomised load/save traffic, with gated and ungated requests.
        for (int n = 0; n < 6; n++) begin
            bit ld;
            int sl;
            int ws;
            ld = 1'($urandom);
            sl = $urandom_range(0, 3);
            ws = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : 99;
            if ($urandom_range(0, 2) == 0) begin
                bk_ena = 1'b0;
                load_req = 1'b1;
                repeat (4) step();
                check("gated_busy", busy, 0);
                load_req = 1'b0;
                bk_ena = 1'b1;
                step();
            end
            start(ld, !ld, 0, 2'(sl));
            if (!ld) model_dirty = 1'b0;
            check("start_dirty", dirty, model_dirty);
            if ($urandom_range(0, 1) != 0) bk_ena = 1'b0;
            serve(ld, 32'(sl) << SB, 16, ws, 99, hs);
            bk_ena = 1'b1;
            finish_op("random", ld, sl, hs);
        end

        // Auto-save after AT idle ticks; a core write restarts the count.
        autosave_en = 1'b1;
        slot = 2'd2;
        bram_wr = 1'b1; step(); bram_wr = 1'b0; model_dirty = 1'b1; step();
        pulse_tick();
        pulse_tick();
        bram_wr = 1'b1; step(); bram_wr = 1'b0; step();
        pulse_tick();
        pulse_tick();
        repeat (3) step();
        check("auto_restart", {30'd0, sd_wr, busy}, 0);
        tick = 1'b1; step(); tick = 1'b0;
        t = 0;
        while (!sd_wr && t < 10) begin
            step();
            t++;
        end
        check("auto_start", sd_wr, 1);
        model_dirty = 1'b0;
        serve(0, 32'h20, 16, 99, 99, hs);
        autosave_en = 1'b0;
        finish_op("autosave", 0, 2, hs);

        // Reset in the middle of a load at sector 7.
        start(1, 0, 0, 1);
        serve(1, 32'h10, 7, 99, 99, hs);
        t = 0;
        while (!sd_rd && t < 100) begin
            step();
            t++;
        end
        check("mid_lba", sd_lba, 32'h17);
        reset = 1'b1;
        step();
        model_dirty = 1'b0;
        check("mid_rst_rd", sd_rd, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_loading", loading, 0);
        check("mid_rst_lba", sd_lba, 0);
        reset = 1'b0;
        step();
        sd_ack = 1'b1;
        sd_buff_wr = 1'b1;
        #1;
        check("post_rst_we", ram_we, 0);
        step();
        step();
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("post_rst_idle", {29'd0, sd_rd, sd_wr, busy}, 0);
            step();
        end
        check("post_rst_dirty", dirty, model_dirty);
        $display("op reset mid-load sector 7 handshakes %0d", hs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
